// File: rtl/ysyx_22050854_mem_arbiter.sv
// Shares one memory port between instruction fetch and load/store, sequencing
// issue, wait and response phases with a timeout that returns an error response.
module ysyx_22050854_mem_arbiter #(
   parameter int unsigned ADDR_W      = 64,
   parameter int unsigned DATA_W      = 64,
   parameter int unsigned PRIO_LS     = 1,
   parameter int unsigned TIMEOUT_CYC = 255
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                if_req_valid,
   output logic                if_req_ready,
   input  logic [ADDR_W-1:0]   if_addr,
   output logic                if_rsp_valid,
   output logic [DATA_W-1:0]   if_rsp_data,
   output logic                if_rsp_err,
   input  logic                ls_req_valid,
   output logic                ls_req_ready,
   input  logic [ADDR_W-1:0]   ls_addr,
   input  logic                ls_wen,
   input  logic [DATA_W-1:0]   ls_wdata,
   input  logic [DATA_W/8-1:0] ls_wmask,
   output logic                ls_rsp_valid,
   output logic [DATA_W-1:0]   ls_rsp_data,
   output logic                ls_rsp_err,
   output logic                mem_req_valid,
   input  logic                mem_req_ready,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic                mem_wen,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_wmask,
   input  logic                mem_rsp_valid,
   input  logic [DATA_W-1:0]   mem_rsp_data,
   output logic                busy,
   output logic                owner_ls
);

   localparam int unsigned MASK_W  = DATA_W / 8;
   localparam int unsigned TIMER_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TIMER_W-1:0] TimeoutVal = TIMER_W'(TIMEOUT_CYC);

   typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

   state_e              state_q;
   logic [TIMER_W-1:0]  timer_q;
   logic                owner_ls_q;
   logic                last_grant_ls_q;
   logic [ADDR_W-1:0]   addr_q;
   logic                wen_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [MASK_W-1:0]   wmask_q;
   logic                if_rsp_valid_q;
   logic                if_rsp_err_q;
   logic [DATA_W-1:0]   if_rsp_data_q;
   logic                ls_rsp_valid_q;
   logic                ls_rsp_err_q;
   logic [DATA_W-1:0]   ls_rsp_data_q;

   logic idle;
   logic grant_ls;
   logic grant_if;
   logic timeout;

   // Under contention LS wins in fixed-priority mode, otherwise whoever was not granted last.
   always_comb begin
      idle     = (state_q == StIdle);
      grant_ls = ls_req_valid && (!if_req_valid || (PRIO_LS != 0) || !last_grant_ls_q);
      grant_if = if_req_valid && !grant_ls;
      timeout  = (timer_q == TimeoutVal);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q         <= StIdle;
         timer_q         <= '0;
         owner_ls_q      <= 1'b0;
         last_grant_ls_q <= 1'b1;
         addr_q          <= '0;
         wen_q           <= 1'b0;
         wdata_q         <= '0;
         wmask_q         <= '0;
         if_rsp_valid_q  <= 1'b0;
         if_rsp_err_q    <= 1'b0;
         if_rsp_data_q   <= '0;
         ls_rsp_valid_q  <= 1'b0;
         ls_rsp_err_q    <= 1'b0;
         ls_rsp_data_q   <= '0;
      end else begin
         if_rsp_valid_q <= 1'b0;
         if_rsp_err_q   <= 1'b0;
         ls_rsp_valid_q <= 1'b0;
         ls_rsp_err_q   <= 1'b0;
         case (state_q)
            StIdle: begin
               if (grant_ls || grant_if) begin
                  state_q         <= StIssue;
                  owner_ls_q      <= grant_ls;
                  last_grant_ls_q <= grant_ls;
                  if (grant_ls) begin
                     addr_q  <= ls_addr;
                     wen_q   <= ls_wen;
                     wdata_q <= ls_wdata;
                     wmask_q <= ls_wmask;
                  end else begin
                     addr_q  <= if_addr;
                     wen_q   <= 1'b0;
                     wdata_q <= '0;
                     wmask_q <= '0;
                  end
               end
            end
            StIssue: begin
               if (mem_req_ready) begin
                  state_q <= StWait;
                  timer_q <= '0;
               end
            end
            StWait: begin
               timer_q <= timer_q + 1'b1;
               // A response arriving on the timeout cycle still counts as a good response.
               if (mem_rsp_valid || timeout) begin
                  state_q <= StIdle;
                  if (owner_ls_q) begin
                     ls_rsp_valid_q <= 1'b1;
                     ls_rsp_err_q   <= !mem_rsp_valid;
                     ls_rsp_data_q  <= (mem_rsp_valid && !wen_q) ? mem_rsp_data : '0;
                  end else begin
                     if_rsp_valid_q <= 1'b1;
                     if_rsp_err_q   <= !mem_rsp_valid;
                     if_rsp_data_q  <= mem_rsp_valid ? mem_rsp_data : '0;
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   always_comb begin
      if_req_ready  = rst && idle && grant_if;
      ls_req_ready  = rst && idle && grant_ls;
      mem_req_valid = (state_q == StIssue);
      busy          = !idle;
   end

   assign mem_addr     = addr_q;
   assign mem_wen      = wen_q;
   assign mem_wdata    = wdata_q;
   assign mem_wmask    = wmask_q;
   assign owner_ls     = owner_ls_q;
   assign if_rsp_valid = if_rsp_valid_q;
   assign if_rsp_err   = if_rsp_err_q;
   assign if_rsp_data  = if_rsp_data_q;
   assign ls_rsp_valid = ls_rsp_valid_q;
   assign ls_rsp_err   = ls_rsp_err_q;
   assign ls_rsp_data  = ls_rsp_data_q;

endmodule

// File: tb/tb_ysyx_22050854_mem_arbiter.sv
// Scoreboard bench: a fixed-priority instance with a scripted memory model and a
// round-robin instance with an always-ready memory, both with a 4-cycle timeout.
module tb_ysyx_22050854_mem_arbiter;

   typedef struct packed {
      logic [63:0] addr;
      logic        wen;
      logic [63:0] wdata;
      logic [7:0]  wmask;
   } req_t;

   typedef struct packed {
      logic [63:0] data;
      logic        err;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        if_req_valid, if_req_ready, if_rsp_valid, if_rsp_err;
   logic [63:0] if_addr, if_rsp_data;
   logic        ls_req_valid, ls_req_ready, ls_wen, ls_rsp_valid, ls_rsp_err;
   logic [63:0] ls_addr, ls_wdata, ls_rsp_data;
   logic [7:0]  ls_wmask;
   logic        mem_req_valid, mem_req_ready, mem_wen, mem_rsp_valid;
   logic [63:0] mem_addr, mem_wdata, mem_rsp_data;
   logic [7:0]  mem_wmask;
   logic        busy, owner_ls;

   logic        rr_if_req_valid, rr_if_req_ready, rr_if_rsp_valid, rr_if_rsp_err;
   logic [63:0] rr_if_addr, rr_if_rsp_data;
   logic        rr_ls_req_valid, rr_ls_req_ready, rr_ls_wen, rr_ls_rsp_valid, rr_ls_rsp_err;
   logic [63:0] rr_ls_addr, rr_ls_wdata, rr_ls_rsp_data;
   logic [7:0]  rr_ls_wmask;
   logic        rr_mem_req_valid, rr_mem_req_ready, rr_mem_wen, rr_mem_rsp_valid;
   logic [63:0] rr_mem_addr, rr_mem_wdata, rr_mem_rsp_data;
   logic [7:0]  rr_mem_wmask;
   logic        rr_busy, rr_owner_ls;

   int          tests_run = 0;
   int          tests_failed = 0;
   req_t        if_reqs[$];
   req_t        ls_reqs[$];
   exp_t        if_exp[$];
   exp_t        ls_exp[$];
   bit          rr_exp[$];
   bit          mem_ready_en;
   int          rsp_lat;
   logic [63:0] rsp_value;
   bit          rr_en;

   ysyx_22050854_mem_arbiter #(.ADDR_W(64), .DATA_W(64), .PRIO_LS(1), .TIMEOUT_CYC(4)) dut (
      .clk(clk), .rst(rst),
      .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
      .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data), .if_rsp_err(if_rsp_err),
      .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_addr(ls_addr),
      .ls_wen(ls_wen), .ls_wdata(ls_wdata), .ls_wmask(ls_wmask),
      .ls_rsp_valid(ls_rsp_valid), .ls_rsp_data(ls_rsp_data), .ls_rsp_err(ls_rsp_err),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
      .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
      .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
      .busy(busy), .owner_ls(owner_ls)
   );

   ysyx_22050854_mem_arbiter #(.ADDR_W(64), .DATA_W(64), .PRIO_LS(0), .TIMEOUT_CYC(4)) dut_rr (
      .clk(clk), .rst(rst),
      .if_req_valid(rr_if_req_valid), .if_req_ready(rr_if_req_ready), .if_addr(rr_if_addr),
      .if_rsp_valid(rr_if_rsp_valid), .if_rsp_data(rr_if_rsp_data), .if_rsp_err(rr_if_rsp_err),
      .ls_req_valid(rr_ls_req_valid), .ls_req_ready(rr_ls_req_ready), .ls_addr(rr_ls_addr),
      .ls_wen(rr_ls_wen), .ls_wdata(rr_ls_wdata), .ls_wmask(rr_ls_wmask),
      .ls_rsp_valid(rr_ls_rsp_valid), .ls_rsp_data(rr_ls_rsp_data), .ls_rsp_err(rr_ls_rsp_err),
      .mem_req_valid(rr_mem_req_valid), .mem_req_ready(rr_mem_req_ready),
      .mem_addr(rr_mem_addr), .mem_wen(rr_mem_wen), .mem_wdata(rr_mem_wdata),
      .mem_wmask(rr_mem_wmask), .mem_rsp_valid(rr_mem_rsp_valid),
      .mem_rsp_data(rr_mem_rsp_data), .busy(rr_busy), .owner_ls(rr_owner_ls)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic req_t mk_req(input logic [63:0] a, input logic w, input logic [63:0] d,
                                   input logic [7:0] m);
      req_t r;
      r.addr = a; r.wen = w; r.wdata = d; r.wmask = m;
      return r;
   endfunction

   task automatic push_if(input logic [63:0] d, input logic e);
      exp_t x;
      x.data = d; x.err = e;
      if_exp.push_back(x);
   endtask

   task automatic push_ls(input logic [63:0] d, input logic e);
      exp_t x;
      x.data = d; x.err = e;
      ls_exp.push_back(x);
   endtask

   task automatic check_reset_outputs(input string p);
      check({p, "_flags"}, 64'({if_req_ready, ls_req_ready, if_rsp_valid, if_rsp_err,
            ls_rsp_valid, ls_rsp_err, mem_req_valid, mem_wen, busy, owner_ls}), 64'd0);
      check({p, "_mem_addr"}, mem_addr, 64'd0);
      check({p, "_mem_wdata"}, mem_wdata, 64'd0);
      check({p, "_mem_wmask"}, 64'(mem_wmask), 64'd0);
      check({p, "_if_rsp_data"}, if_rsp_data, 64'd0);
      check({p, "_ls_rsp_data"}, ls_rsp_data, 64'd0);
   endtask

   task automatic wait_grant(input string name, input bit ls, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 40 && !ok; i++) begin
         @(negedge clk);
         ok = ls ? ls_req_ready : if_req_ready;
      end
      check(name, 64'(ok), 64'd1);
   endtask

   task automatic wait_handshake(input string name);
      int n;
      n = 0;
      while (!(mem_req_valid && mem_req_ready) && n < 30) begin
         @(negedge clk);
         n++;
      end
      check(name, 64'(mem_req_valid && mem_req_ready), 64'd1);
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 60 && (if_exp.size() + ls_exp.size()) > 0; i++) @(negedge clk);
      check(name, 64'(if_exp.size() + ls_exp.size()), 64'd0);
   endtask

   // IF requester: holds valid and address until ready is seen, then releases.
   initial begin : if_requester
      req_t r;
      bit   got;
      if_req_valid = 1'b0;
      if_addr = '0;
      forever begin
         @(posedge clk); #1;
         if (if_reqs.size() > 0) begin
            r = if_reqs.pop_front();
            if_req_valid = 1'b1;
            if_addr = r.addr;
            got = 1'b0;
            for (int i = 0; i < 60 && !got; i++) begin
               @(negedge clk);
               got = if_req_ready;
            end
            check("if_req_accept", 64'(got), 64'd1);
            @(posedge clk); #1;
            if_req_valid = 1'b0;
         end
      end
   end

   initial begin : ls_requester
      req_t r;
      bit   got;
      ls_req_valid = 1'b0;
      ls_addr = '0; ls_wen = 1'b0; ls_wdata = '0; ls_wmask = '0;
      forever begin
         @(posedge clk); #1;
         if (ls_reqs.size() > 0) begin
            r = ls_reqs.pop_front();
            ls_req_valid = 1'b1;
            ls_addr = r.addr; ls_wen = r.wen; ls_wdata = r.wdata; ls_wmask = r.wmask;
            got = 1'b0;
            for (int i = 0; i < 60 && !got; i++) begin
               @(negedge clk);
               got = ls_req_ready;
            end
            check("ls_req_accept", 64'(got), 64'd1);
            @(posedge clk); #1;
            ls_req_valid = 1'b0;
         end
      end
   end

   // Memory model: responds rsp_lat cycles into WAIT (0 = never).
   initial begin : mem_model
      bit hs;
      bit act;
      int cnt;
      mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
      act = 1'b0; cnt = 0;
      forever begin
         @(posedge clk);
         hs = mem_req_valid && mem_req_ready;
         #1;
         mem_req_ready = mem_ready_en;
         mem_rsp_valid = 1'b0;
         if (hs) begin
            act = 1'b1;
            cnt = 0;
         end
         if (act) begin
            cnt++;
            if (cnt == rsp_lat) begin
               mem_rsp_valid = 1'b1;
               mem_rsp_data = rsp_value;
               act = 1'b0;
            end
         end
      end
   end

   initial begin : rr_driver
      rr_if_req_valid = 1'b0; rr_ls_req_valid = 1'b0;
      rr_if_addr = 64'h100; rr_ls_addr = 64'h200;
      rr_ls_wen = 1'b0; rr_ls_wdata = '0; rr_ls_wmask = '0;
      rr_mem_req_ready = 1'b1; rr_mem_rsp_valid = 1'b0; rr_mem_rsp_data = 64'h55;
      forever begin
         @(posedge clk); #1;
         rr_if_req_valid = rr_en;
         rr_ls_req_valid = rr_en;
         rr_mem_rsp_valid = rr_busy && !rr_mem_req_valid;
      end
   end

   initial begin : monitor
      exp_t e;
      bit   o;
      forever begin
         @(negedge clk);
         if (if_rsp_valid) begin
            check("if_rsp_expected", 64'(if_exp.size() > 0), 64'd1);
            if (if_exp.size() > 0) begin
               e = if_exp.pop_front();
               check("if_rsp_data", if_rsp_data, e.data);
               check("if_rsp_err", 64'(if_rsp_err), 64'(e.err));
            end
         end
         if (ls_rsp_valid) begin
            check("ls_rsp_expected", 64'(ls_exp.size() > 0), 64'd1);
            if (ls_exp.size() > 0) begin
               e = ls_exp.pop_front();
               check("ls_rsp_data", ls_rsp_data, e.data);
               check("ls_rsp_err", 64'(ls_rsp_err), 64'(e.err));
            end
         end
         if ((rr_if_rsp_valid || rr_ls_rsp_valid) && rr_exp.size() > 0) begin
            o = rr_exp.pop_front();
            check("rr_grant_order", 64'(rr_ls_rsp_valid), 64'(o));
            check("rr_rsp_data", rr_ls_rsp_valid ? rr_ls_rsp_data : rr_if_rsp_data, 64'h55);
            check("rr_rsp_err", 64'(rr_if_rsp_err || rr_ls_rsp_err), 64'd0);
         end
      end
   end

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      bit ok;
      int n;
      rst = 1'b1; mem_ready_en = 1'b1; rsp_lat = 1; rsp_value = '0; rr_en = 1'b0;
      #1 rst = 1'b0;
      #1 check_reset_outputs("reset");
      repeat (3) @(negedge clk);
      rst = 1'b1;

      // Single IF read at minimum latency.
      @(negedge clk);
      rsp_value = 64'h13;
      push_if(64'h13, 1'b0);
      if_reqs.push_back(mk_req(64'h8000_0000, 1'b0, 64'd0, 8'h00));
      wait_grant("if_read_grant", 1'b0, ok);
      @(negedge clk);
      check("if_read_issue", 64'(mem_req_valid), 64'd1);
      check("if_read_addr", mem_addr, 64'h8000_0000);
      check("if_read_wen_wmask", 64'({mem_wen, mem_wmask}), 64'd0);
      n = 1;
      while (!if_rsp_valid && n < 30) begin
         @(negedge clk);
         n++;
      end
      check("if_read_latency", 64'(n), 64'd3);
      drain("if_read_drain");

      // Hung memory: error response 5 cycles into WAIT, late response dropped.
      @(negedge clk);
      rsp_lat = 7; rsp_value = 64'h77;
      push_if(64'd0, 1'b1);
      if_reqs.push_back(mk_req(64'h8000_3000, 1'b0, 64'd0, 8'h00));
      wait_grant("to_grant", 1'b0, ok);
      wait_handshake("to_handshake");
      n = 0;
      while (!if_rsp_valid && n < 30) begin
         @(negedge clk);
         n++;
      end
      check("to_latency", 64'(n), 64'd6);
      repeat (4) @(negedge clk);
      check("to_late_rsp_ignored", if_rsp_data, 64'd0);
      check("to_idle", 64'(busy), 64'd0);
      drain("to_drain");

      // Memory stalls the request for 10 cycles; ISSUE has no timeout.
      @(negedge clk);
      mem_ready_en = 1'b0; rsp_lat = 2; rsp_value = 64'h1234;
      push_ls(64'd0, 1'b0);
      ls_reqs.push_back(mk_req(64'h8000_2000, 1'b1, 64'hA5A5_5A5A_0F0F_F0F0, 8'h0F));
      wait_grant("stall_grant", 1'b1, ok);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("stall_hold", 64'(mem_req_valid && busy && mem_wen && mem_addr == 64'h8000_2000 &&
               mem_wdata == 64'hA5A5_5A5A_0F0F_F0F0 && mem_wmask == 8'h0F), 64'd1);
      end
      mem_ready_en = 1'b1;
      drain("stall_drain");

      // Both request together: LS store first, IF granted back-to-back after.
      @(negedge clk);
      rsp_lat = 1; rsp_value = 64'hDEAD_BEEF_0BAD_F00D;
      push_ls(64'd0, 1'b0);
      push_if(64'hDEAD_BEEF_0BAD_F00D, 1'b0);
      ls_reqs.push_back(mk_req(64'h8000_1000, 1'b1, 64'h1122_3344_5566_7788, 8'hFF));
      if_reqs.push_back(mk_req(64'h8000_0004, 1'b0, 64'd0, 8'h00));
      wait_grant("prio_ls_grant", 1'b1, ok);
      check("prio_if_blocked", 64'(if_req_ready), 64'd0);
      @(negedge clk);
      check("prio_ls_owner", 64'(owner_ls), 64'd1);
      check("prio_ls_wen_wmask", 64'({mem_wen, mem_wmask}), 64'h1FF);
      check("prio_ls_wdata", mem_wdata, 64'h1122_3344_5566_7788);
      check("prio_ls_addr", mem_addr, 64'h8000_1000);
      wait_grant("prio_if_grant", 1'b0, ok);
      check("prio_back_to_back", 64'(ls_rsp_valid), 64'd1);
      @(negedge clk);
      check("prio_if_wen_wmask", 64'({mem_wen, mem_wmask}), 64'd0);
      check("prio_if_addr", mem_addr, 64'h8000_0004);
      check("prio_if_owner", 64'(owner_ls), 64'd0);
      drain("prio_drain");

      // Reset in the middle of WAIT: no response for the aborted transaction.
      @(negedge clk);
      rsp_lat = 0;
      if_reqs.push_back(mk_req(64'h8000_5000, 1'b0, 64'd0, 8'h00));
      wait_grant("mid_rst_grant", 1'b0, ok);
      wait_handshake("mid_rst_handshake");
      @(negedge clk);
      #2 rst = 1'b0;
      #1 check_reset_outputs("mid_rst");
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (8) @(negedge clk);
      check("mid_rst_idle", 64'(busy), 64'd0);

      @(negedge clk);
      rsp_lat = 1; rsp_value = 64'h99;
      push_ls(64'h99, 1'b0);
      ls_reqs.push_back(mk_req(64'h8000_4000, 1'b0, 64'd0, 8'h00));
      wait_grant("post_rst_grant", 1'b1, ok);
      drain("post_rst_drain");

      // Round-robin instance with both requesters always valid.
      @(negedge clk);
      rr_exp.push_back(1'b0); rr_exp.push_back(1'b1);
      rr_exp.push_back(1'b0); rr_exp.push_back(1'b1);
      rr_en = 1'b1;
      for (int i = 0; i < 200 && rr_exp.size() > 0; i++) @(negedge clk);
      check("rr_done", 64'(rr_exp.size()), 64'd0);
      rr_en = 1'b0;
      repeat (10) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
